// File: rtl/snake_render.sv
// -----------------------------------------------------------------------------
// snake_render
//
// Rasterises a snake (a list of 4-bit x/y cell coordinates) into a GRIDxGRID
// occupancy map and streams the map out one row per handshake.
//
// Frame sequence: IDLE -> CLEAR -> WALK -> SCAN -> DONE -> IDLE
//   IDLE  : wait for start; latch the snake vector and the clamped count.
//   CLEAR : zero the occupancy map in one cycle.
//   WALK  : mark one segment per cycle and flag any cell hit twice.
//   SCAN  : present rows 0..GRID-1 with a valid/ready handshake.
//   DONE  : one-cycle frame_done pulse.
//
// Ports
//   slw_clk    in   clock, all state changes on the rising edge
//   reset      in   synchronous active-high reset
//   snake      in   8*MAX_SEG packed segments, seg k = bits [8k+7:8k],
//                   [7:4]=y, [3:0]=x; segment 0 is the tail
//   seg_count  in   number of valid segments (clamped to MAX_SEG)
//   start      in   single-cycle frame request, honoured only in IDLE
//   busy       out  high while a frame is in progress
//   row_valid  out  a row is presented on row_y/row_bits
//   row_ready  in   consumer accepts the presented row
//   row_y      out  index of the presented row
//   row_bits   out  occupancy of the presented row, bit x = cell (x,row_y)
//   collision  out  some cell was written by two or more segments this frame
//   frame_done out  one-cycle pulse after the last row is accepted
// -----------------------------------------------------------------------------
module snake_render #(
    parameter int MAX_SEG = 225,
    parameter int GRID    = 16
) (
    input  logic                 slw_clk,
    input  logic                 reset,
    input  logic [8*MAX_SEG-1:0] snake,
    input  logic [7:0]           seg_count,
    input  logic                 start,
    output logic                 busy,
    output logic                 row_valid,
    input  logic                 row_ready,
    output logic [3:0]           row_y,
    output logic [GRID-1:0]      row_bits,
    output logic                 collision,
    output logic                 frame_done
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        WALK  = 3'd2,
        SCAN  = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t                state_reg;
    state_t                state_next;

    logic [8*MAX_SEG-1:0]  snake_reg;
    logic [7:0]            count_reg;
    logic [7:0]            ptr_reg;
    logic [3:0]            row_reg;
    logic                  collision_reg;
    logic [GRID-1:0]       map_reg [GRID];

    logic [7:0]            count_clamped;
    logic [7:0]            seg_arr [MAX_SEG];
    logic [7:0]            cur_seg;
    logic [3:0]            cur_x;
    logic [3:0]            cur_y;
    logic                  start_accept;
    logic                  last_row;

    // Split the latched vector into addressable segments.
    generate
        for (genvar gi = 0; gi < MAX_SEG; gi++) begin : g_seg
            assign seg_arr[gi] = snake_reg[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        count_clamped = seg_count;
        if (int'(seg_count) > MAX_SEG) begin
            count_clamped = 8'(MAX_SEG);
        end
    end

    assign cur_seg      = seg_arr[ptr_reg];
    assign cur_x        = cur_seg[3:0];
    assign cur_y        = cur_seg[7:4];
    assign start_accept = (state_reg == IDLE) && start;
    assign last_row     = (row_reg == 4'(GRID-1));

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge slw_clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = CLEAR;
                end
            end
            CLEAR: begin
                // An empty snake has nothing to walk: go straight to the scan.
                if (count_reg == 8'd0) begin
                    state_next = SCAN;
                end else begin
                    state_next = WALK;
                end
            end
            WALK: begin
                if (ptr_reg == count_reg - 8'd1) begin
                    state_next = SCAN;
                end
            end
            SCAN: begin
                if (row_ready && last_row) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------ datapath
    // The snake vector is pure data; it only needs to be captured on start.
    always_ff @(posedge slw_clk) begin
        if (!reset && start_accept) begin
            snake_reg <= snake;
        end
    end

    always_ff @(posedge slw_clk) begin
        if (reset) begin
            count_reg     <= 8'd0;
            ptr_reg       <= 8'd0;
            row_reg       <= 4'd0;
            collision_reg <= 1'b0;
            for (int r = 0; r < GRID; r++) begin
                map_reg[r] <= '0;
            end
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        count_reg     <= count_clamped;
                        collision_reg <= 1'b0;
                    end
                end
                CLEAR: begin
                    ptr_reg <= 8'd0;
                    row_reg <= 4'd0;
                    for (int r = 0; r < GRID; r++) begin
                        map_reg[r] <= '0;
                    end
                end
                WALK: begin
                    // Map writes land next cycle, so back-to-back segments on
                    // the same cell still see the earlier mark.
                    if (map_reg[cur_y][cur_x]) begin
                        collision_reg <= 1'b1;
                    end
                    map_reg[cur_y][cur_x] <= 1'b1;
                    ptr_reg               <= ptr_reg + 8'd1;
                end
                SCAN: begin
                    if (row_ready) begin
                        row_reg <= last_row ? 4'd0 : row_reg + 4'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------- outputs
    assign busy       = (state_reg != IDLE);
    assign row_valid  = (state_reg == SCAN);
    assign row_y      = row_reg;
    assign row_bits   = row_valid ? map_reg[row_reg] : '0;
    assign collision  = collision_reg;
    assign frame_done = (state_reg == DONE);

endmodule

// File: tb/tb_snake_render.sv
// -----------------------------------------------------------------------------
// tb_snake_render
//
// Table-driven frames: each table entry describes a snake, a consumer ready
// pattern and the expected collision flag / frame latency.  The expected rows
// are produced by a small occupancy model and pushed into a queue before the
// frame starts; they are popped and compared as the DUT hands rows over.
// Hand-written sequences cover reset mid-scan and start coinciding with reset.
// -----------------------------------------------------------------------------
module tb_snake_render;

    localparam int MAX_SEG = 225;
    localparam int GRID    = 16;

    logic                 slw_clk;
    logic                 reset;
    logic [8*MAX_SEG-1:0] snake;
    logic [7:0]           seg_count;
    logic                 start;
    logic                 busy;
    logic                 row_valid;
    logic                 row_ready;
    logic [3:0]           row_y;
    logic [GRID-1:0]      row_bits;
    logic                 collision;
    logic                 frame_done;

    snake_render #(
        .MAX_SEG (MAX_SEG),
        .GRID    (GRID)
    ) dut (
        .slw_clk    (slw_clk),
        .reset      (reset),
        .snake      (snake),
        .seg_count  (seg_count),
        .start      (start),
        .busy       (busy),
        .row_valid  (row_valid),
        .row_ready  (row_ready),
        .row_y      (row_y),
        .row_bits   (row_bits),
        .collision  (collision),
        .frame_done (frame_done)
    );

    initial slw_clk = 1'b0;
    always #5 slw_clk = ~slw_clk;

    // mode: 0 = always ready, 1 = ready pattern 1,0,0 repeating, 2 = random
    // exp_coll: 0/1 constant, 2 = take the model's answer
    // exp_lat : edges from start sampling to frame_done, -1 = not checked
    typedef struct {
        logic [63:0] segs;
        int          count;
        int          mode;
        bit          rand_all;
        bit          disturb;
        int          exp_coll;
        int          exp_lat;
    } vec_t;

    typedef struct packed {
        logic [3:0]  y;
        logic [15:0] bits;
    } row_t;

    vec_t vecs [7];
    row_t exp_q [$];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_busy"},       32'(busy),       32'd0);
        chk({tag, "_row_valid"},  32'(row_valid),  32'd0);
        chk({tag, "_row_y"},      32'(row_y),      32'd0);
        chk({tag, "_row_bits"},   32'(row_bits),   32'd0);
        chk({tag, "_collision"},  32'(collision),  32'd0);
        chk({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    endtask

    // Build snake input and push expected rows; returns model collision.
    task automatic prepare(input vec_t v, output logic coll);
        logic [15:0] m [16];
        logic [7:0]  s;
        int          n;
        for (int k = 0; k < MAX_SEG; k++) begin
            snake[8*k +: 8] = 8'($urandom);
        end
        if (!v.rand_all) begin
            for (int k = 0; k < 8; k++) begin
                snake[8*k +: 8] = v.segs[8*k +: 8];
            end
        end
        seg_count = 8'(v.count);
        n = (v.count > MAX_SEG) ? MAX_SEG : v.count;
        for (int r = 0; r < 16; r++) m[r] = 16'h0;
        coll = 1'b0;
        for (int k = 0; k < n; k++) begin
            s = snake[8*k +: 8];
            if (m[s[7:4]][s[3:0]]) coll = 1'b1;
            m[s[7:4]][s[3:0]] = 1'b1;
        end
        for (int r = 0; r < 16; r++) begin
            exp_q.push_back('{y: 4'(r), bits: m[r]});
        end
    endtask

    task automatic run_vec(input int idx);
        vec_t        v;
        logic        model_coll;
        logic        want_coll;
        row_t        e;
        bit          done;
        bit          hold;
        logic [3:0]  held_y;
        logic [15:0] held_bits;
        int          edges;
        v = vecs[idx];
        prepare(v, model_coll);
        want_coll = (v.exp_coll == 2) ? model_coll : v.exp_coll[0];

        @(posedge slw_clk); #1;
        start = 1'b1;
        @(posedge slw_clk); #1;          // start-sampling edge
        start = 1'b0;
        chk($sformatf("v%0d_busy_after_start", idx), 32'(busy), 32'd1);

        edges = 0;
        done  = 1'b0;
        hold  = 1'b0;
        for (int cyc = 0; cyc < 400 && !done; cyc++) begin
            case (v.mode)
                0:       row_ready = 1'b1;
                1:       row_ready = (cyc % 3 == 0);
                default: row_ready = 1'($urandom);
            endcase
            if (v.disturb) begin
                start = (cyc == 1);
                if (cyc == 8) begin
                    for (int k = 0; k < MAX_SEG; k++) snake[8*k +: 8] = 8'($urandom);
                    seg_count = 8'($urandom);
                end
            end
            @(negedge slw_clk);
            if (hold) begin
                chk($sformatf("v%0d_stall_y", idx),    32'(row_y),    32'(held_y));
                chk($sformatf("v%0d_stall_bits", idx), 32'(row_bits), 32'(held_bits));
                hold = 1'b0;
            end
            if (row_valid) begin
                if (row_ready) begin
                    if (exp_q.size() == 0) begin
                        chk($sformatf("v%0d_extra_row", idx), 32'(row_y), 32'hFFFF);
                    end else begin
                        e = exp_q.pop_front();
                        chk($sformatf("v%0d_row_y", idx),    32'(row_y),    32'(e.y));
                        chk($sformatf("v%0d_row_bits", idx), 32'(row_bits), 32'(e.bits));
                        $display("v%0d row %0d bits %04h (exp %04h)", idx, row_y, row_bits, e.bits);
                    end
                end else begin
                    hold      = 1'b1;
                    held_y    = row_y;
                    held_bits = row_bits;
                end
            end
            @(posedge slw_clk); #1;
            edges++;
            if (frame_done) done = 1'b1;
        end
        start = 1'b0;
        chk($sformatf("v%0d_frame_done_seen", idx), 32'(done), 32'd1);
        if (v.exp_lat >= 0) begin
            chk($sformatf("v%0d_latency", idx), 32'(edges), 32'(v.exp_lat));
        end
        chk($sformatf("v%0d_collision", idx), 32'(collision), 32'(want_coll));
        chk($sformatf("v%0d_valid_low_in_done", idx), 32'(row_valid), 32'd0);
        chk($sformatf("v%0d_rows_left", idx), 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        @(posedge slw_clk); #1;
        chk($sformatf("v%0d_done_one_cycle", idx), 32'(frame_done), 32'd0);
        chk($sformatf("v%0d_busy_idle", idx), 32'(busy), 32'd0);
        chk($sformatf("v%0d_collision_held", idx), 32'(collision), 32'(want_coll));
    endtask

    task automatic reset_mid_scan();
        logic dummy;
        bit   hit;
        vec_t v;
        v = '{segs: 64'h55_56_55, count: 3, mode: 0, rand_all: 0, disturb: 0,
              exp_coll: 1, exp_lat: 20};
        prepare(v, dummy);
        row_ready = 1'b1;
        @(posedge slw_clk); #1;
        start = 1'b1;
        @(posedge slw_clk); #1;
        start = 1'b0;
        hit = 1'b0;
        for (int cyc = 0; cyc < 100 && !hit; cyc++) begin
            @(negedge slw_clk);
            if (row_valid && row_y == 4'd7) hit = 1'b1;
        end
        chk("rst_reached_row7", 32'(hit), 32'd1);
        reset = 1'b1;
        @(posedge slw_clk); #1;
        reset = 1'b0;
        check_idle_outputs("rst_mid_scan");
        $display("reset mid-scan: busy %0b valid %0b row_y %0d coll %0b", busy, row_valid, row_y, collision);
        exp_q.delete();
    endtask

    initial begin
        vecs[0] = '{segs: 64'h13_12_11,       count: 3, mode: 0, rand_all: 0, disturb: 0, exp_coll: 0, exp_lat: 20};
        vecs[1] = '{segs: 64'h55_56_55,       count: 3, mode: 0, rand_all: 0, disturb: 0, exp_coll: 1, exp_lat: 20};
        vecs[2] = '{segs: 64'h13_12_11,       count: 0, mode: 0, rand_all: 0, disturb: 0, exp_coll: 0, exp_lat: 17};
        vecs[3] = '{segs: 64'h0F_F0_FF_00,    count: 4, mode: 1, rand_all: 0, disturb: 0, exp_coll: 0, exp_lat: -1};
        vecs[4] = '{segs: 64'h15_14_13_12_11, count: 5, mode: 0, rand_all: 0, disturb: 1, exp_coll: 0, exp_lat: 22};
        vecs[5] = '{segs: 64'h0,              count: 255, mode: 2, rand_all: 1, disturb: 0, exp_coll: 2, exp_lat: -1};
        vecs[6] = '{segs: 64'hA3,             count: 1, mode: 0, rand_all: 0, disturb: 0, exp_coll: 0, exp_lat: 18};

        reset     = 1'b1;
        start     = 1'b0;
        row_ready = 1'b0;
        seg_count = 8'd0;
        snake     = '0;
        repeat (3) @(posedge slw_clk);
        #1;
        reset = 1'b0;
        check_idle_outputs("reset");

        for (int i = 0; i < 7; i++) begin
            run_vec(i);
        end

        reset_mid_scan();
        run_vec(0);

        // start coinciding with reset must be dropped
        @(posedge slw_clk); #1;
        reset = 1'b1;
        start = 1'b1;
        @(posedge slw_clk); #1;
        reset = 1'b0;
        start = 1'b0;
        chk("rst_start_busy", 32'(busy), 32'd0);
        @(posedge slw_clk); #1;
        chk("rst_start_busy_later", 32'(busy), 32'd0);
        $display("start during reset: busy %0b", busy);

        run_vec(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
